// File: rtl/alib_points_pkg.sv
// Shared definitions for the point FIFO read path.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
//
// Contents: default coordinate/counter widths, point bus width helper,
// reader FSM state encoding.
package alib_points_pkg;

  localparam int PT_W_DEF  = 16;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Packed (x,y,z) point bus width for a given coordinate width.
  function automatic int pt_bus_w(input int pt_w);
    return 3 * pt_w;
  endfunction

endpackage

// File: rtl/point_skid_buf.sv
// Two-entry register buffer holding captured points ahead of the output port.
// Latency: write in cycle N is visible on rd_data/rd_valid in cycle N+1.
// Backpressure: head held stable until rd_ready; caller must never write when full without reading.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   wr_en, wr_data     push one entry
//   rd_valid, rd_ready head entry valid / consumer accepts head
//   rd_data            head entry (registered, no path from rd_ready)
//   count              current occupancy 0..2
module point_skid_buf #(
  parameter int W = 49
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [W-1:0] rd_data,
  output logic [1:0]   count
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;

  assign rd_valid = (count != 2'd0);
  assign rd_data  = head_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (wr_en) begin
            head_q <= wr_data;
            count  <= 2'd1;
          end
        end
        2'd1: begin
          if (wr_en && rd_ready) begin
            // Head leaves and the new entry takes its place: occupancy unchanged.
            head_q <= wr_data;
          end else if (wr_en) begin
            tail_q <= wr_data;
            count  <= 2'd2;
          end else if (rd_ready) begin
            count  <= 2'd0;
          end
        end
        2'd2: begin
          if (rd_ready) begin
            head_q <= tail_q;
            if (wr_en) tail_q <= wr_data;
            else       count  <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/points_fifo_reader.sv
// Pops (x,y,z) points from the point FIFO and presents them as a valid/ready stream with frame marking.
// Latency: pop in cycle N -> m_valid earliest in cycle N+2; sustains 1 point/cycle.
// Backpressure: pops are credit-limited to the 2-entry buffer; m_* held stable until m_ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   enable                   1 = issue FIFO reads, 0 = stop issuing and drain
//   frame_len                points per frame (0 = no framing)
//   fifo_empty, fifo_rd_en   FIFO status / pop request
//   fifo_x/y/z               FIFO registered read data (valid the cycle after a pop)
//   m_valid/m_ready          output handshake
//   m_x/m_y/m_z, m_last      output point and end-of-frame flag
//   frames_done              completed-frame count (wraps)
//   busy                     FSM not idle or buffer holding points
module points_fifo_reader
  import alib_points_pkg::*;
#(
  parameter int PT_W  = PT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] frame_len,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [PT_W-1:0]  fifo_x,
  input  logic [PT_W-1:0]  fifo_y,
  input  logic [PT_W-1:0]  fifo_z,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PT_W-1:0]  m_x,
  output logic [PT_W-1:0]  m_y,
  output logic [PT_W-1:0]  m_z,
  output logic             m_last,
  output logic [CNT_W-1:0] frames_done,
  output logic             busy
);

  localparam int BUF_W = pt_bus_w(PT_W) + 1;

  state_t           state;
  logic             in_flight;
  logic [1:0]       buf_count;
  logic             buf_valid;
  logic [BUF_W-1:0] buf_head;
  logic             xfer;
  logic [2:0]       credit_used;
  logic [2:0]       credit_limit;
  logic             can_pop;

  // Capture-side frame position (decides m_last as points enter the buffer)
  // and delivery-side position (advances on output transfers).
  logic [CNT_W-1:0] cap_idx;
  logic [CNT_W-1:0] frame_len_q;
  logic [CNT_W-1:0] point_idx;
  logic [CNT_W-1:0] len_eff;
  logic             cap_last;

  assign xfer = buf_valid && m_ready;

  // A slot freed by this cycle's transfer can be re-used by this cycle's pop,
  // which is what allows 1 point/cycle with only two buffer entries.
  assign credit_used  = {1'b0, buf_count} + {2'b00, in_flight};
  assign credit_limit = 3'd2 + {2'b00, xfer};
  assign can_pop      = (credit_used < credit_limit);
  assign fifo_rd_en   = !rst && (state == ST_RUN) && !fifo_empty && can_pop;

  // A new frame picks up frame_len on its first captured point; later points
  // of the same frame use the latched copy so mid-frame changes do not tear it.
  always_comb begin
    len_eff  = (cap_idx == '0) ? frame_len : frame_len_q;
    cap_last = 1'b0;
    if (len_eff != '0) cap_last = (cap_idx == len_eff - CNT_W'(1));
  end

  point_skid_buf #(
    .W(BUF_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (in_flight),
    .wr_data  ({fifo_x, fifo_y, fifo_z, cap_last}),
    .rd_valid (buf_valid),
    .rd_ready (m_ready),
    .rd_data  (buf_head),
    .count    (buf_count)
  );

  assign m_valid = buf_valid;
  assign {m_x, m_y, m_z, m_last} = buf_head;
  assign busy = (state != ST_IDLE) || (buf_count != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      in_flight   <= 1'b0;
      cap_idx     <= '0;
      frame_len_q <= '0;
      point_idx   <= '0;
      frames_done <= '0;
    end else begin
      in_flight <= fifo_rd_en;

      case (state)
        ST_IDLE:  if (enable) state <= ST_RUN;
        ST_RUN:   if (!enable) state <= ST_FLUSH;
        ST_FLUSH: begin
          if (enable)
            state <= ST_RUN;
          else if (!in_flight && (buf_count == 2'd0))
            state <= ST_IDLE;
        end
        default:  state <= ST_IDLE;
      endcase

      if (in_flight) begin
        if (cap_idx == '0) frame_len_q <= frame_len;
        if (len_eff != '0) cap_idx <= cap_last ? '0 : cap_idx + CNT_W'(1);
      end

      if (xfer) begin
        if (m_last) begin
          point_idx   <= '0;
          frames_done <= frames_done + CNT_W'(1);
        end else if (frame_len_q != '0) begin
          point_idx <= point_idx + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_points_fifo_reader.sv
module tb_points_fifo_reader;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic        last;
  } pt_t;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] frame_len;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [15:0] fifo_x, fifo_y, fifo_z;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_x, m_y, m_z;
  logic        m_last;
  logic [15:0] frames_done;
  logic        busy;

  points_fifo_reader #(.PT_W(16), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .frame_len   (frame_len),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_x      (fifo_x),
    .fifo_y      (fifo_y),
    .fifo_z      (fifo_z),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_x         (m_x),
    .m_y         (m_y),
    .m_z         (m_z),
    .m_last      (m_last),
    .frames_done (frames_done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pt_t fq[$];   // contents of the modelled point FIFO
  pt_t sb[$];   // expected output points, in order

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int pops = 0;
  int xfers = 0;
  int first_pop = -1;
  int first_vld = -1;
  int first_x = -1;
  int last_x = -1;
  int max_out = 0;
  int exp_idx = 0;
  int exp_len = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  // Queue n points into the FIFO model and their expected outputs into the scoreboard.
  task automatic load(input int n, input int base);
    pt_t p;
    for (int i = 0; i < n; i++) begin
      if (exp_idx == 0) exp_len = int'(frame_len);
      p.x    = 16'(base + i);
      p.y    = 16'(base + i + 100);
      p.z    = 16'(base + i + 200);
      p.last = (exp_len != 0) && (exp_idx == exp_len - 1);
      if (exp_len != 0) exp_idx = p.last ? 0 : exp_idx + 1;
      fq.push_back(p);
      sb.push_back(p);
    end
    fifo_empty = (fq.size() == 0);
  endtask

  // One clock: sample outputs on the falling edge, then update the FIFO model after the rising edge.
  task automatic step();
    bit do_pop;
    bit do_xfer;
    pt_t p;
    @(negedge clk);
    cyc++;
    do_pop  = fifo_rd_en && !fifo_empty;
    do_xfer = m_valid && m_ready;
    check("rd_empty", 64'(fifo_rd_en & fifo_empty), 64'(0));
    if (pops - xfers > max_out) max_out = pops - xfers;
    if (do_pop && first_pop < 0) first_pop = cyc;
    if (m_valid) begin
      if (first_vld < 0) first_vld = cyc;
      if (sb.size() == 0) begin
        check("extra_pt", 64'(1), 64'(0));
      end else begin
        check("pt", 64'({m_x, m_y, m_z, m_last}), 64'(sb[0]));
        if (do_xfer) begin
          void'(sb.pop_front());
          xfers++;
          if (first_x < 0) first_x = cyc;
          last_x = cyc;
        end
      end
    end
    @(posedge clk);
    #1;
    if (do_pop) begin
      p = fq.pop_front();
      fifo_x = p.x;
      fifo_y = p.y;
      fifo_z = p.z;
      pops++;
    end
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      step();
      k++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'(0));
  endtask

  task automatic clear_trackers();
    first_pop = -1;
    first_vld = -1;
    first_x   = -1;
    last_x    = -1;
    max_out   = 0;
  endtask

  initial begin
    int p0;
    int x0;
    int k;
    rst = 1'b1;
    enable = 1'b1;
    frame_len = 16'd0;
    m_ready = 1'b1;
    fifo_empty = 1'b1;
    fifo_x = '0;
    fifo_y = '0;
    fifo_z = '0;

    // Reset held with enable and a non-empty FIFO
    load(8, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_rd_en", 64'(fifo_rd_en), 64'(0));
      check("rst_vld", 64'(m_valid), 64'(0));
      check("rst_frames", 64'(frames_done), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
    end
    check("rst_nopop", 64'(pops), 64'(0));

    // Streaming, no framing
    clear_trackers();
    rst = 1'b0;
    wait_drain(40);
    check("latency", 64'(first_vld - first_pop), 64'(2));
    check("thruput", 64'(last_x - first_x), 64'(7));
    check("pops8", 64'(pops), 64'(8));

    // Backpressure mid-stream
    clear_trackers();
    load(8, 20);
    repeat (4) step();
    m_ready = 1'b0;
    repeat (10) step();
    m_ready = 1'b1;
    wait_drain(40);
    check("max_out", 64'(max_out), 64'(2));
    check("bp_xfers", 64'(xfers), 64'(16));
    check("bp_pops", 64'(pops), 64'(16));

    // Framing with frame_len=3, then 1
    frame_len = 16'd3;
    load(7, 40);
    wait_drain(40);
    check("frames2", 64'(frames_done), 64'(2));
    load(2, 47);
    wait_drain(40);
    check("frames3", 64'(frames_done), 64'(3));
    frame_len = 16'd1;
    load(4, 50);
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      step();
    end
    m_ready = 1'b1;
    wait_drain(40);
    check("frames7", 64'(frames_done), 64'(7));

    // Drop enable with points outstanding, then resume the same frame
    frame_len = 16'd3;
    load(5, 60);
    repeat (3) step();
    enable = 1'b0;
    step();
    p0 = pops;
    check("flush_busy1", 64'(busy), 64'(1));
    repeat (8) step();
    check("flush_nopop", 64'(pops), 64'(p0));
    check("flush_out", 64'(xfers), 64'(pops));
    check("flush_vld", 64'(m_valid), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));
    enable = 1'b1;
    wait_drain(40);
    check("frames8", 64'(frames_done), 64'(8));

    // Reset in the middle of a stalled stream
    frame_len = 16'd4;
    load(6, 80);
    x0 = xfers;
    k = 0;
    while (xfers < x0 + 2 && k < 20) begin
      step();
      k++;
    end
    check("pre_rst_xfers", 64'(xfers - x0), 64'(2));
    m_ready = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    #1;
    check("midrst_rd_en", 64'(fifo_rd_en), 64'(0));
    step();
    rst = 1'b0;
    fq.delete();
    sb.delete();
    fifo_empty = 1'b1;
    exp_idx = 0;
    check("midrst_vld", 64'(m_valid), 64'(0));
    check("midrst_frames", 64'(frames_done), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    m_ready = 1'b1;
    load(4, 90);
    wait_drain(40);
    check("post_rst_frames", 64'(frames_done), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
